ksa_pipe: RTL
=============

Name: ksa_pipe

Overview:
- Parametrised, pipelined Kogge-Stone adder/subtractor. Generalises the fixed 16-bit combinational adder cell to any WIDTH.
- Adds carry-in, an add/sub mode, a configurable pipeline depth, valid/ready flow control and a sideband tag.
- Sits in the arithmetic benchmark/datapath library as the standard streaming add unit that feeds accumulators and ALU wrappers.

Parameters:
WIDTH, 16, operand and sum width in bits (>=2); prefix levels L = ceil(log2(WIDTH)).
PIPE, 2, register stages between input and output, legal 1..L+1; latency = PIPE cycles.
TAG_W, 4, width of sideband tag carried alongside each operation (>=1).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand beat valid.
in_ready  out  1  unit can accept a beat this cycle.
in_a  in  WIDTH  operand A.
in_b  in  WIDTH  operand B.
in_cin  in  1  carry-in (add mode); in sub mode it is ignored and forced to 1.
in_sub  in  1  1 = A - B (B inverted, cin=1), 0 = A + B + cin.
in_tag  in  TAG_W  sideband, returned unchanged with the result.
out_valid  out  1  result beat valid.
out_ready  in  1  downstream accepts result.
out_sum  out  WIDTH  result, modulo 2^WIDTH.
out_cout  out  1  carry-out of MSB; in sub mode 1 = no borrow (A >= B unsigned).
out_tag  out  TAG_W  tag of this result.

Behaviour:
- Arithmetic: bit-generate g=a&b', propagate p=a^b' with b'=in_sub ? ~in_b : in_b; Kogge-Stone prefix over L levels with cin injected as g[-1]; sum = p ^ carry; cout = carry out of bit WIDTH-1. Bit-exact to {cout,sum} = a + b' + cin_eff.
- Pipeline: PIPE register stages, each holding valid bit, partial g/p state, tag. Register placement among prefix levels is free, but the last stage drives outputs directly (outputs registered, no combinational in->out path). Latency exactly PIPE cycles when not stalled.
- Handshake: a beat transfers on in_valid&in_ready; a result on out_valid&out_ready. Stage k advances when stage k+1 is empty or advancing. in_ready = !stage0_valid | stage0_advancing (combinational from out_ready through the chain). Throughput 1 beat/cycle with out_ready held high.
- Stall: while out_valid & !out_ready, out_sum/out_cout/out_tag/out_valid hold stable. Bubbles upstream compress, so up to PIPE beats are buffered before in_ready drops.
- Ordering: results emerge in acceptance order; no beat dropped or duplicated.
- in_valid without in_ready: unit takes nothing; sender must hold the beat.
- Reset (async assert, sync release): all stage valids 0, all data/tag registers 0. Hence out_valid=0, out_sum=0, out_cout=0, out_tag=0, and in_ready=1 from the first cycle after release. Reset mid-operation discards all in-flight beats.
- Wrap-around: all-ones + 1 gives sum 0, cout 1. No saturation.

Optional Feature:
KSA_OVF_EN: defined -> extra output out_ovf (1 bit), signed two's-complement overflow = carry into MSB XOR carry out of MSB. Pipelined and stalled with the beat; reset value 0. Undefined -> port absent, no extra logic.

Test Plan:
- WIDTH=16, PIPE=2: A=0xFFFF, B=0x0001, cin=0, add, tag=3 -> 2 cycles later sum=0x0000, cout=1, tag=3 (ovf=0 if KSA_OVF_EN).
- Sub: A=0x0005, B=0x0007 -> sum=0xFFFE, cout=0. A=0x8000, B=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Streaming: 100 consecutive beats, out_ready=1 -> one result per cycle after PIPE-cycle fill, in order, in_ready never low.
- Back-pressure: out_ready=0 for 10 cycles while in_valid=1 -> exactly PIPE beats accepted, then in_ready=0, outputs stable. Release -> all beats delivered in order.
- Reset mid-stream: assert rst_n=0 with 2 beats in flight -> out_valid=0 and out_sum=0 immediately; after release, no stale beat ever emerges.
- Sweep WIDTH in {2,7,16,33,64}, PIPE in {1, L+1}: 10k random beats with random stalls vs {cout,sum}=a+b'+cin model -> zero mismatches.

Source files
------------

// File: rtl/ksa_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ksa_pipe
// Purpose  : Parametrised, pipelined Kogge-Stone adder/subtractor with
//            valid/ready flow control and a sideband tag.
//            {out_cout,out_sum} = in_a + (in_sub ? ~in_b : in_b) + cin_eff,
//            where cin_eff = in_sub ? 1 : in_cin. Latency is PIPE cycles.
// Ports    : clk, rst_n (async active-low)
//            in_valid/in_ready, in_a, in_b, in_cin, in_sub, in_tag  (input beat)
//            out_valid/out_ready, out_sum, out_cout, out_tag        (result beat)
//            out_ovf (only with KSA_OVF_EN): signed two's-complement overflow
// Options  : `define KSA_OVF_EN to add the out_ovf port and its pipeline bit.
// Revision : 1.0 - initial release
// ============================================================================
module ksa_pipe #(
    parameter int WIDTH = 16,
    parameter int PIPE  = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic [TAG_W-1:0] out_tag
`ifdef KSA_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int LVLS = $clog2(WIDTH);
    localparam int MID  = (PIPE > 1) ? PIPE - 1 : 1;

    // Last prefix level completed by stage k. Chunk 0 is the bit-level g/p
    // generation, chunks 1..LVLS are the prefix levels; they are spread
    // evenly over the PIPE stages, the final stage always ending at LVLS.
    function automatic int end_lvl(input int k);
        return ((k + 1) * (LVLS + 1)) / PIPE - 1;
    endfunction

    // Apply Kogge-Stone levels lo..hi to a group generate/propagate vector.
    function automatic logic [2*WIDTH-1:0] prefix(input logic [WIDTH-1:0] g,
                                                  input logic [WIDTH-1:0] p,
                                                  input int lo,
                                                  input int hi);
        logic [WIDTH-1:0] gn;
        logic [WIDTH-1:0] pn;
        int               d;
        gn = g;
        pn = p;
        for (int lv = 1; lv <= LVLS; lv++) begin
            if (lv >= lo && lv <= hi) begin
                d  = 1 << (lv - 1);
                gn = gn | (pn & (gn << d));
                // Bits below the span keep their propagate unchanged.
                pn = pn & ((pn << d) | ({WIDTH{1'b1}} >> (WIDTH - d)));
            end
        end
        return {gn, pn};
    endfunction

    logic [PIPE-1:0]  valid_q;
    logic [PIPE-1:0]  rdy;
    logic [TAG_W-1:0] tag_q [PIPE];

    logic [WIDTH-1:0] mid_g  [MID];
    logic [WIDTH-1:0] mid_p  [MID];
    logic [WIDTH-1:0] mid_hs [MID];
    logic [MID-1:0]   mid_cin;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    generate
        for (genvar k = 0; k < PIPE; k++) begin : g_stage
            // Stage k can take a beat if it or any stage after it is empty,
            // or if the result is leaving this cycle (bubbles compress).
            localparam logic [PIPE-1:0] BELOW = PIPE'((1 << k) - 1);
            localparam int LO = (k == 0) ? 1 : end_lvl(k - 1) + 1;
            localparam int HI = end_lvl(k);

            logic [WIDTH-1:0]   src_g;
            logic [WIDTH-1:0]   src_p;
            logic [WIDTH-1:0]   src_hs;
            logic               src_cin;
            logic               src_v;
            logic [TAG_W-1:0]   src_tag;
            logic [2*WIDTH-1:0] pf;
            logic               load;

            assign rdy[k] = out_ready | ~(&(valid_q | BELOW));

            if (k == 0) begin : g_src_in
                logic [WIDTH-1:0] b_eff;
                logic             cin_eff;
                assign b_eff   = in_sub ? ~in_b : in_b;
                assign cin_eff = in_sub | in_cin;
                assign src_hs  = in_a ^ b_eff;
                assign src_p   = src_hs;
                // Fold carry-in into bit 0 so the prefix needs only LVLS levels.
                assign src_g   = (in_a & b_eff)
                               | {{(WIDTH-1){1'b0}}, src_hs[0] & cin_eff};
                assign src_cin = cin_eff;
                assign src_v   = in_valid;
                assign src_tag = in_tag;
            end else begin : g_src_reg
                assign src_g   = mid_g[k-1];
                assign src_p   = mid_p[k-1];
                assign src_hs  = mid_hs[k-1];
                assign src_cin = mid_cin[k-1];
                assign src_v   = valid_q[k-1];
                assign src_tag = tag_q[k-1];
            end

            assign pf   = prefix(src_g, src_p, LO, HI);
            assign load = rdy[k] & src_v;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q[k] <= 1'b0;
                    tag_q[k]   <= '0;
                end else begin
                    if (rdy[k]) valid_q[k] <= src_v;
                    if (load)   tag_q[k]   <= src_tag;
                end
            end

            if (k < PIPE - 1) begin : g_mid
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        mid_g[k]   <= '0;
                        mid_p[k]   <= '0;
                        mid_hs[k]  <= '0;
                        mid_cin[k] <= 1'b0;
                    end else if (load) begin
                        mid_g[k]   <= pf[2*WIDTH-1:WIDTH];
                        mid_p[k]   <= pf[WIDTH-1:0];
                        mid_hs[k]  <= src_hs;
                        mid_cin[k] <= src_cin;
                    end
                end
            end else begin : g_last
                logic [WIDTH-1:0] grp_g;
                logic [WIDTH-1:0] carry;
                assign grp_g = pf[2*WIDTH-1:WIDTH];
                // Carry into bit i is the group generate of bits i-1..0.
                assign carry = {grp_g[WIDTH-2:0], src_cin};

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        sum_q  <= '0;
                        cout_q <= 1'b0;
                    end else if (load) begin
                        sum_q  <= src_hs ^ carry;
                        cout_q <= grp_g[WIDTH-1];
                    end
                end
`ifdef KSA_OVF_EN
                logic ovf_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)    ovf_q <= 1'b0;
                    else if (load) ovf_q <= grp_g[WIDTH-2] ^ grp_g[WIDTH-1];
                end
                assign out_ovf = ovf_q;
`endif
            end
        end
    endgenerate

    assign in_ready  = rdy[0];
    assign out_valid = valid_q[PIPE-1];
    assign out_tag   = tag_q[PIPE-1];
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule
`default_nettype wire
